// File: rtl/servo_pwm_ramp.sv
// Purpose: Avalon-MM servo PWM generator; the live pulse width ramps toward a software target once per period.
// Latency: register writes land at the clock edge; readdata is valid one cycle after read; pwm_out lags the us compare by 1 cycle.
// Backpressure: none; the slave never stalls, so there is no waitrequest.
//
// Ports:
//   clk, reset_n                      - system clock, synchronous active-low reset
//   address, read, write, writedata   - Avalon-MM slave command side
//   readdata                          - registered read data, held until the next read
//   pwm_out                           - registered servo PWM (conduit export)
//
// Register map (word addresses):
//   0 TARGET  R/W  [15:0]   written value is clamped to [MIN_US, MAX_US]
//   1 CURRENT RO   [15:0]   live pulse width in us
//   2 CTRL    R/W  [0] enable, [15:8] step in us per period (0 = jump)
//   3 STATUS  R/W1C [0] at_target (RO), [1] clamp_flag (write 1 clears)
module servo_pwm_ramp #(
    parameter int CLK_HZ     = 50000000,
    parameter int PERIOD_US  = 20000,
    parameter int MIN_US     = 1000,
    parameter int MAX_US     = 2000,
    parameter int DEFAULT_US = 1500
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        pwm_out
);

    localparam int             DIV        = CLK_HZ / 1000000;
    localparam int             PSW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PSW-1:0] PRESC_LAST = PSW'(DIV - 1);
    localparam logic [15:0]    CNT_LAST   = 16'(PERIOD_US - 1);
    localparam logic [15:0]    MIN_W      = 16'(MIN_US);
    localparam logic [15:0]    MAX_W      = 16'(MAX_US);
    localparam logic [15:0]    DEF_W      = 16'(DEFAULT_US);

    localparam logic [1:0] ADDR_TARGET  = 2'd0;
    localparam logic [1:0] ADDR_CURRENT = 2'd1;
    localparam logic [1:0] ADDR_CTRL    = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    // Timebase
    logic [PSW-1:0] presc;
    logic [15:0]    us_cnt;
    logic           us_tick;
    logic           boundary;

    // Register state
    logic [15:0] target;
    logic [15:0] current;
    logic        enable;
    logic [7:0]  step;
    logic        clamp_flag;
    logic        run;

    // Combinational helpers
    logic [15:0] wr_target;
    logic        wr_clamped;
    logic [15:0] diff;
    logic [15:0] step_w;
    logic [15:0] current_next;
    logic        at_target;
    logic [31:0] rd_mux;

    // Upper write-data bits have no register behind them.
    logic unused_wd;
    assign unused_wd = &{1'b0, writedata[31:16]};

    assign us_tick   = (presc == PRESC_LAST);
    assign boundary  = us_tick && (us_cnt == CNT_LAST);
    assign at_target = (current == target);
    assign step_w    = {8'd0, step};

    // Clamp an incoming TARGET write into the legal servo range.
    always_comb begin
        wr_target  = writedata[15:0];
        wr_clamped = 1'b0;
        if (writedata[15:0] < MIN_W) begin
            wr_target  = MIN_W;
            wr_clamped = 1'b1;
        end else if (writedata[15:0] > MAX_W) begin
            wr_target  = MAX_W;
            wr_clamped = 1'b1;
        end
    end

    // Rate-limited move toward target; both operands stay inside
    // [MIN_US, MAX_US], so the 16-bit add/subtract cannot wrap.
    always_comb begin
        current_next = target;
        if (target >= current) begin
            diff = target - current;
        end else begin
            diff = current - target;
        end
        if ((step != 8'd0) && (diff > step_w)) begin
            if (target > current) begin
                current_next = current + step_w;
            end else begin
                current_next = current - step_w;
            end
        end
    end

    always_comb begin
        rd_mux = 32'd0;
        case (address)
            ADDR_TARGET:  rd_mux = {16'd0, target};
            ADDR_CURRENT: rd_mux = {16'd0, current};
            ADDR_CTRL:    rd_mux = {16'd0, step, 7'd0, enable};
            ADDR_STATUS:  rd_mux = {30'd0, clamp_flag, at_target};
            default:      rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            presc      <= '0;
            us_cnt     <= 16'd0;
            run        <= 1'b0;
            target     <= DEF_W;
            current    <= DEF_W;
            enable     <= 1'b0;
            step       <= 8'd0;
            clamp_flag <= 1'b0;
            pwm_out    <= 1'b0;
            readdata   <= 32'd0;
        end else begin
            // Free-running timebase, independent of enable.
            if (us_tick) begin
                presc  <= '0;
                us_cnt <= (us_cnt == CNT_LAST) ? 16'd0 : us_cnt + 16'd1;
            end else begin
                presc  <= presc + 1'b1;
            end

            // Width changes and output arming happen only at the period
            // boundary, using the target/step registered before this edge.
            if (boundary) begin
                run     <= enable;
                current <= current_next;
            end

            pwm_out <= run && enable && (us_cnt < current);

            // rd_mux sees pre-write state, so a same-cycle read/write
            // returns the old value.
            if (read) begin
                readdata <= rd_mux;
            end

            if (write) begin
                case (address)
                    ADDR_TARGET: begin
                        target <= wr_target;
                        if (wr_clamped) begin
                            clamp_flag <= 1'b1;
                        end
                    end
                    ADDR_CTRL: begin
                        enable <= writedata[0];
                        step   <= writedata[15:8];
                        // Disarm immediately so a later re-enable waits for
                        // the next boundary instead of producing a runt pulse.
                        if (!writedata[0]) begin
                            run <= 1'b0;
                        end
                    end
                    ADDR_STATUS: begin
                        if (writedata[1]) begin
                            clamp_flag <= 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
